// File: rtl/period_meter_multi.sv
// Multi-channel period / high-time meter with per-channel synchronisers and saturating counters.
// Optional 4-capture averaging is enabled by defining PERIOD_AVG_EN.
module period_meter_multi #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 28,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic [NUM_CH-1:0]       sig_in,
    input  logic [NUM_CH-1:0]       mode_sel,
    input  logic                    freeze,
    output logic [NUM_CH*CNT_W-1:0] period_out,
    output logic [NUM_CH-1:0]       valid_pulse,
    output logic [NUM_CH-1:0]       data_valid,
    output logic [NUM_CH-1:0]       overflow
);

    typedef enum logic {StIdle, StRun} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   edge_q;
        logic                   mode_q;
        state_e                 state_q;
        logic [CNT_W-1:0]       cnt_q;
        logic [CNT_W-1:0]       res_q;
        logic                   sat_q;
        logic                   valid_q;
        logic                   dv_q;
        logic                   ovf_q;

        logic                   sig_s;
        logic                   rise;
        logic                   fall;
        logic                   mode_chg;
        logic                   start;
        logic                   capture;
        logic [CNT_W-1:0]       cnt_inc_d;
        logic                   out_fire;
        logic [CNT_W-1:0]       out_val;
        logic                   out_ovf;

        always_comb begin
            sig_s     = sync_q[SYNC_STAGES-1];
            rise      = sig_s & ~edge_q;
            fall      = ~sig_s & edge_q;
            mode_chg  = mode_sel[i] != mode_q;
            start     = ~mode_chg && (state_q == StIdle) && rise;
            capture   = ~mode_chg && (state_q == StRun) && (mode_q ? fall : rise);
            cnt_inc_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
        end

`ifdef PERIOD_AVG_EN
        logic [CNT_W-1:0] hist_q [4];
        logic [3:0]       hsat_q;
        logic [CNT_W+1:0] sum_q;
        logic [CNT_W+1:0] sum_d;
        logic [2:0]       hcnt_q;

        // Entries start at zero, so subtracting the oldest is correct while filling.
        always_comb begin
            sum_d    = sum_q + {2'b00, cnt_q} - {2'b00, hist_q[3]};
            out_fire = hcnt_q >= 3'd3;
            out_val  = sum_d[CNT_W+1:2];
            out_ovf  = |{hsat_q[2:0], sat_q};
        end

        always_ff @(posedge clk_clk) begin
            if (reset_reset || mode_chg) begin
                for (int k = 0; k < 4; k++) hist_q[k] <= '0;
                hsat_q <= '0;
                sum_q  <= '0;
                hcnt_q <= '0;
            end else if (capture && !freeze) begin
                hist_q[0] <= cnt_q;
                hist_q[1] <= hist_q[0];
                hist_q[2] <= hist_q[1];
                hist_q[3] <= hist_q[2];
                hsat_q    <= {hsat_q[2:0], sat_q};
                sum_q     <= sum_d;
                if (hcnt_q != 3'd4) hcnt_q <= hcnt_q + 3'd1;
            end
        end
`else
        always_comb begin
            out_fire = 1'b1;
            out_val  = cnt_q;
            out_ovf  = sat_q;
        end
`endif

        always_ff @(posedge clk_clk) begin
            if (reset_reset) begin
                sync_q  <= '0;
                edge_q  <= 1'b0;
                mode_q  <= mode_sel[i];
                state_q <= StIdle;
                cnt_q   <= '0;
                res_q   <= '0;
                sat_q   <= 1'b0;
                valid_q <= 1'b0;
                dv_q    <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in[i]};
                edge_q  <= sig_s;
                mode_q  <= mode_sel[i];
                valid_q <= 1'b0;
                if (mode_chg) begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    sat_q   <= 1'b0;
                    dv_q    <= 1'b0;
                end else if (start) begin
                    state_q <= StRun;
                    cnt_q   <= CntOne;
                    sat_q   <= 1'b0;
                end else if (capture) begin
                    // Restart happens even when frozen so the next interval is clean.
                    sat_q <= 1'b0;
                    if (mode_q) state_q <= StIdle;
                    else        cnt_q   <= CntOne;
                    if (!freeze && out_fire) begin
                        res_q   <= out_val;
                        ovf_q   <= out_ovf;
                        valid_q <= 1'b1;
                        dv_q    <= 1'b1;
                    end
                end else if (state_q == StRun) begin
                    cnt_q <= cnt_inc_d;
                    if (cnt_inc_d == CntMax) sat_q <= 1'b1;
                end
            end
        end

        assign period_out[i*CNT_W +: CNT_W] = res_q;
        assign valid_pulse[i]               = valid_q;
        assign data_valid[i]                = dv_q;
        assign overflow[i]                  = ovf_q;
    end

endmodule

// File: doc/period_meter_multi.md
Name: period_meter_multi

Overview:
Parametrised multi-channel period / pulse-width meter. Successor to the fixed four-channel, 28-bit period PIO path.
- Measures each external signal in clk_clk cycles.
- Per-channel mode: period or high-time.
- Saturation/overflow flagging and a freeze control for the push-button "hold" function.
- Sits between the board inputs and the processor-side PIO/decode logic; its outputs replace the software-timed period registers.

Parameters:
NUM_CH, 4, number of independent measurement channels (1..16)
CNT_W, 28, counter and result width per channel (8..32)
SYNC_STAGES, 2, input synchroniser flops per channel (2..4)

Ports:
clk_clk  in  1  system clock; every flop uses it
reset_reset  in  1  synchronous, active-high reset
sig_in  in  NUM_CH  asynchronous measured signals, bit i = channel i
mode_sel  in  NUM_CH  per channel: 0 = rise-to-rise period, 1 = high pulse width
freeze  in  1  1 = hold all period_out values; counting continues
period_out  out  NUM_CH*CNT_W  channel i result at bits [i*CNT_W +: CNT_W]
valid_pulse  out  NUM_CH  one-cycle strobe when period_out[i] updates
data_valid  out  NUM_CH  sticky: channel i holds at least one result since reset or mode change
overflow  out  NUM_CH  1 = current period_out[i] is a saturated measurement

Behaviour:
- Reset (reset_reset=1 at a clk_clk edge): synchroniser and edge flops, counters, period_out, valid_pulse, data_valid and overflow all go to 0; every channel enters IDLE. Reset mid-measurement discards partial counts.
- Input path: SYNC_STAGES flops, then a 1-flop edge detector. An edge is "detected" SYNC_STAGES+1 cycles after the sig_in transition.
- Counter cnt (CNT_W bits), per channel:
  - On the detected start edge: cnt <= 1.
  - Otherwise, in RUN: cnt <= cnt+1, saturating at 2^CNT_W-1.
  - Reaching the maximum sets the internal flag sat.
- Signal of period P cycles therefore captures P. Minimum measurable value is 2 in mode 0 and 1 in mode 1.
- States per channel: IDLE, RUN.
- mode 0 (period):
  - IDLE + rise -> RUN (start, no capture).
  - RUN + rise -> capture cnt, restart cnt <= 1, stay RUN.
- mode 1 (high time):
  - IDLE + rise -> RUN.
  - RUN + fall -> capture cnt, go to IDLE.
  - Fall in IDLE is ignored.
- Capture, when freeze=0, takes effect on the cycle after the detected edge:
  - period_out[i] <= cnt;
  - overflow[i] <= sat;
  - valid_pulse[i] = 1 for exactly one cycle;
  - data_valid[i] <= 1;
  - sat cleared.
- Capture with freeze=1: the result is discarded. No valid_pulse; outputs unchanged. The restart still happens, so the next interval is measured normally.
- mode_sel[i] change (compared with a registered copy): channel goes to IDLE, cnt <= 0, sat <= 0, data_valid[i] <= 0; period_out[i] is held. This takes priority over an edge in the same cycle.
- Edge and saturation in the same cycle: the capture uses the saturated value and overflow=1.
- Channels are fully independent. Simultaneous captures on several channels all complete in the same cycle.

Optional Feature:
PERIOD_AVG_EN defined:
- Each channel keeps its last 4 raw captures (4-entry shift register plus a CNT_W+2-bit running sum).
- period_out[i] = sum >> 2, truncated.
- valid_pulse fires only once 4 captures have accumulated since arm/mode change, then on every capture after that.
- overflow[i] = OR of the sat flags of the 4 entries.
- Mode change or reset flushes the history.
- Frozen captures do not enter the history.

PERIOD_AVG_EN undefined: raw single-capture results as described above; no history storage is synthesised.

Test Plan:
1. Reset, then NUM_CH=4, CNT_W=28, ch0 mode 0, square wave of period 100 cycles -> after the 2nd rise, period_out[0]=100, valid_pulse[0] once per 100 cycles, data_valid[0]=1, overflow[0]=0.
2. ch1 mode 1, 30-high/70-low wave -> period_out[1]=30 each period; ch0 running at the same time is unaffected (still 100).
3. CNT_W=8, ch2 period 300 -> period_out[2]=255, overflow[2]=1. Switch input to period 200 -> period_out[2]=200, overflow[2]=0.
4. freeze=1 for 5 periods on ch0 (period 100 -> 150) -> period_out[0] holds 100 with no valid_pulse. freeze=0 -> the next capture gives 150.
5. Toggle mode_sel[0] in the same cycle as a detected rise -> no capture, data_valid[0]=0, period_out[0] retains its old value. The first new result appears after the second subsequent edge.
6. reset_reset asserted mid-period for 1 cycle -> all outputs 0 next cycle. Measurement resumes from IDLE. With PERIOD_AVG_EN, periods 100,104,100,104 -> the first valid output is 102.
